bin2bcd_seq: RTL and testbench



---
 rtl/display_pkg.sv | 22 ++
 rtl/bin2bcd_seq_if.sv | 20 ++
 rtl/bcd_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 tb/tb_bin2bcd_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the display path: digit width, default digit count,
// converter FSM encoding and the largest value representable in BCD.
package display_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DIGITS_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Largest value that fits in the given number of decimal digits.
    function automatic int unsigned max_val(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake between the score producer and the BCD converter.
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_WIDTH = 10,
    parameter int unsigned DIGITS    = 3
);
    import display_pkg::*;

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;

    logic                 start;
    logic [BIN_WIDTH-1:0] binario;
    logic [BCD_W-1:0]     valor;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    modport master (output start, binario, input valor, busy, done, overflow);
    modport slave  (input start, binario, output valor, busy, done, overflow);

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_add3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted_c
);

    assign adjusted_c = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock; the result
// register only changes on completion so the display never sees partial work.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 10,
    parameter int unsigned DIGITS    = DIGITS_DEF
) (
    input logic          clk,
    input logic          reset,
    bin2bcd_seq_if.slave bus
);

    localparam int unsigned BCD_W   = DIGIT_W * DIGITS;
    localparam int unsigned SCR_W   = BCD_W + BIN_WIDTH;
    localparam int unsigned CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam int unsigned MAX_VAL = max_val(DIGITS);

    logic [1:0]       state,       state_nxt;
    logic [SCR_W-1:0] scratch,     scratch_nxt;
    logic [CNT_W-1:0] cnt,         cnt_nxt;
    logic             ovf_pending, ovf_pending_nxt;
    logic [BCD_W-1:0] valor,       valor_nxt;
    logic             overflow,    overflow_nxt;
    logic             busy,        busy_nxt;
    logic             done,        done_nxt;

    logic [BCD_W-1:0] bcd_adj;

    // Per-digit correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .digit      (scratch[BIN_WIDTH + g*DIGIT_W +: DIGIT_W]),
            .adjusted_c (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_nxt       = state;
        scratch_nxt     = scratch;
        cnt_nxt         = cnt;
        ovf_pending_nxt = ovf_pending;
        valor_nxt       = valor;
        overflow_nxt    = overflow;
        done_nxt        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    scratch_nxt     = {BCD_W'(0), bus.binario};
                    cnt_nxt         = CNT_W'(BIN_WIDTH);
                    ovf_pending_nxt = (32'(bus.binario) > MAX_VAL);
                    state_nxt       = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Top corrected bit is always shifted out; digits stay <= 9.
                scratch_nxt = SCR_W'({bcd_adj, scratch[BIN_WIDTH-1:0]} << 1);
                cnt_nxt     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
                if (ovf_pending) begin
                    valor_nxt    = {DIGITS{4'h9}};
                    overflow_nxt = 1'b1;
                end else begin
                    valor_nxt    = scratch[SCR_W-1 -: BCD_W];
                    overflow_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            valor       <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            scratch     <= scratch_nxt;
            cnt         <= cnt_nxt;
            ovf_pending <= ovf_pending_nxt;
            valor       <= valor_nxt;
            overflow    <= overflow_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    assign bus.valor    = valor;
    assign bus.overflow = overflow;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with hand-computed BCD results.
module tb_bin2bcd_seq;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   lat;
    int   busy_cnt;
    int   hold_err;
    int   done_cnt;
    logic [11:0] seen_valor;

    bin2bcd_seq_if #(.BIN_WIDTH(10), .DIGITS(3)) bus ();

    bin2bcd_seq #(.BIN_WIDTH(10), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; lat counts edges since the caller's last tick.
    task automatic wait_done;
        logic [11:0] prev;
        prev     = bus.valor;
        lat      = 0;
        busy_cnt = 0;
        hold_err = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.valor !== prev) hold_err++;
            tick();
            lat++;
        end
    endtask

    task automatic do_conv(input string tag, input logic [9:0] v,
                           input logic [11:0] ev, input logic eo);
        bus.binario = v;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done();
        chk({tag, "_latency"}, 32'(lat), 32'd11);
        chk({tag, "_valor"}, 32'(bus.valor), 32'(ev));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_valor_hold"}, 32'(hold_err), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.binario = 10'd77;
        tick();
        tick();
        chk("rst_valor", 32'(bus.valor), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("post_rst_idle", 32'(bus.busy), 32'd0);

        do_conv("zero", 10'd0, 12'h000, 1'b0);
        chk("zero_busy_cycles", 32'(busy_cnt), 32'd11);
        do_conv("v255", 10'd255, 12'h255, 1'b0);
        do_conv("v999", 10'd999, 12'h999, 1'b0);
        do_conv("v9", 10'd9, 12'h009, 1'b0);
        do_conv("v1000", 10'd1000, 12'h999, 1'b1);
        do_conv("v1023", 10'd1023, 12'h999, 1'b1);
        do_conv("v42", 10'd42, 12'h042, 1'b0);

        // Start and input changes while busy must be ignored.
        bus.binario = 10'd123;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.binario = 10'd777;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.binario = 10'd5;
        done_cnt    = 0;
        seen_valor  = 12'hfff;
        for (int i = 0; i < 15; i++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                seen_valor = bus.valor;
            end
            tick();
        end
        chk("midflight_done_count", 32'(done_cnt), 32'd1);
        chk("midflight_valor", 32'(seen_valor), 32'h123);

        // Reset mid-conversion aborts it.
        bus.binario = 10'd500;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valor", 32'(bus.valor), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        do_conv("v321", 10'd321, 12'h321, 1'b0);

        // Back-to-back: restart in the done cycle.
        bus.binario = 10'd58;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done();
        chk("b2b_first_latency", 32'(lat), 32'd11);
        chk("b2b_first_valor", 32'(bus.valor), 32'h058);
        bus.binario = 10'd613;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
        chk("b2b_accept_done", 32'(bus.done), 32'd0);
        wait_done();
        chk("b2b_second_latency", 32'(lat), 32'd11);
        chk("b2b_second_valor", 32'(bus.valor), 32'h613);
        chk("b2b_second_overflow", 32'(bus.overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
